// File: rtl/adc_sample_sequencer.sv
// Snapshots enabled ADC channels every SAMPLE_INTERVAL cycles and writes them into per-channel RAM rings.
// Latency: wr_req rises 2 cycles after a tick; never stalls ADC data, ticks arriving mid-sequence are dropped and counted.
module adc_sample_sequencer #(
  parameter int NUM_CH          = 2,
  parameter int DATA_W          = 32,
  parameter int ADDR_W          = 12,
  parameter int DEPTH           = 640,
  parameter int SAMPLE_INTERVAL = 175000,
  parameter logic [NUM_CH*ADDR_W-1:0] BASE_ADDRS = {12'h800, 12'h400},
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(SAMPLE_INTERVAL)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [NUM_CH-1:0]        ch_mask,
  input  logic [NUM_CH*DATA_W-1:0] adc_data,
  output logic                     wr_req,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  input  logic                     wr_ack,
  output logic [NUM_CH*PTR_W-1:0]  wr_ptr,
  output logic [NUM_CH-1:0]        wrap_pulse,
  output logic                     overrun,
  input  logic                     overrun_clr,
  output logic [7:0]               overrun_cnt,
  output logic                     busy
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, WRITE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              tick;
  logic [NUM_CH-1:0] pending;
  logic [DATA_W-1:0] snap  [NUM_CH];
  logic [PTR_W-1:0]  ptr_q [NUM_CH];
  logic [ADDR_W-1:0] base  [NUM_CH];
  logic [CH_W-1:0]   cur_ch;
  logic [CH_W-1:0]   scan_ch;
  logic              scan_found;

  assign tick = enable && (cnt == CNT_W'(SAMPLE_INTERVAL - 1));
  assign busy = (state != IDLE);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign base[g]                    = BASE_ADDRS[g*ADDR_W +: ADDR_W];
    assign wr_ptr[g*PTR_W +: PTR_W]   = ptr_q[g];
  end

  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(SAMPLE_INTERVAL - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Lowest pending channel is serviced first.
  always_comb begin
    scan_found = 1'b0;
    scan_ch    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pending[i]) begin
        scan_found = 1'b1;
        scan_ch    = CH_W'(i);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      pending     <= '0;
      cur_ch      <= '0;
      wr_req      <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      wrap_pulse  <= '0;
      overrun     <= 1'b0;
      overrun_cnt <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        ptr_q[i] <= '0;
        snap[i]  <= '0;
      end
    end else begin
      wrap_pulse <= '0;

      if (overrun_clr) begin
        overrun     <= 1'b0;
        overrun_cnt <= '0;
      end else if (tick && state != IDLE) begin
        overrun <= 1'b1;
        if (overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
      end

      case (state)
        IDLE: begin
          if (tick) begin
            for (int i = 0; i < NUM_CH; i++) snap[i] <= adc_data[i*DATA_W +: DATA_W];
            pending <= ch_mask;
            state   <= SCAN;
          end
        end
        SCAN: begin
          if (!scan_found) begin
            state <= IDLE;
          end else begin
            cur_ch  <= scan_ch;
            wr_addr <= base[scan_ch] + ADDR_W'(ptr_q[scan_ch]);
            wr_data <= snap[scan_ch];
            wr_req  <= 1'b1;
            state   <= WRITE;
          end
        end
        WRITE: begin
          if (wr_ack) begin
            wr_req          <= 1'b0;
            pending[cur_ch] <= 1'b0;
            if (ptr_q[cur_ch] == PTR_W'(DEPTH - 1)) begin
              ptr_q[cur_ch]      <= '0;
              wrap_pulse[cur_ch] <= 1'b1;
            end else begin
              ptr_q[cur_ch] <= ptr_q[cur_ch] + PTR_W'(1);
            end
            state <= SCAN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Directed + randomized bench for adc_sample_sequencer against a transaction-level timeline model.
module tb_adc_sample_sequencer;

  localparam int SI = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  ch_mask;
  logic [63:0] adc_data;
  logic        wr_req;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_ack;
  logic [3:0]  wr_ptr;
  logic [1:0]  wrap_pulse;
  logic        overrun;
  logic        overrun_clr;
  logic [7:0]  overrun_cnt;
  logic        busy;

  adc_sample_sequencer #(
    .NUM_CH(2), .DATA_W(32), .ADDR_W(12), .DEPTH(4), .SAMPLE_INTERVAL(SI),
    .BASE_ADDRS({12'h800, 12'h400})
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .ch_mask(ch_mask), .adc_data(adc_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .wr_ptr(wr_ptr),
    .wrap_pulse(wrap_pulse), .overrun(overrun), .overrun_clr(overrun_clr),
    .overrun_cnt(overrun_cnt), .busy(busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
    int          ch;
  } wr_t;

  logic [11:0] tb_base [2] = '{12'h400, 12'h800};

  // Model state describes the cycle that follows each negedge update.
  wr_t         mq[$];
  logic [1:0]  mptr [2];
  logic [1:0]  m_wrap;
  bit          m_req, m_busy, m_ovr, m_rst_chk;
  int          m_ocnt, mcnt, cyc, req_rise, idle_at;
  logic [11:0] obs_addr[$];
  logic [31:0] obs_data[$];
  int          wrap_seen;

  task automatic model_reset();
    mq.delete();
    mptr[0] = 0; mptr[1] = 0;
    m_wrap = 0; m_req = 0; m_busy = 0; m_ovr = 0; m_ocnt = 0; mcnt = 0;
    req_rise = -1; idle_at = -1; m_rst_chk = 1;
  endtask

  initial begin
    cyc = 0; wrap_seen = 0;
    model_reset();
  end

  always @(negedge clock) begin
    bit   tk, drop;
    logic [1:0] nwrap;
    wr_t  e;
    cyc++;
    if (cyc == req_rise) m_req = 1;
    if (cyc == idle_at)  m_busy = 0;

    chk("wr_req", wr_req, m_req);
    chk("busy", busy, m_busy);
    chk("wr_ptr", wr_ptr, {mptr[1], mptr[0]});
    chk("wrap_pulse", wrap_pulse, m_wrap);
    chk("overrun", overrun, m_ovr);
    chk("overrun_cnt", overrun_cnt, m_ocnt);
    if (m_req && mq.size() > 0) begin
      chk("wr_addr", wr_addr, mq[0].addr);
      chk("wr_data", wr_data, mq[0].data);
    end
    if (m_rst_chk) begin
      chk("rst_addr", wr_addr, 0);
      chk("rst_data", wr_data, 0);
      m_rst_chk = 0;
    end
    if (wrap_pulse[0]) wrap_seen++;

    if (reset) begin
      model_reset();
    end else begin
      if (wr_req && wr_ack) begin
        obs_addr.push_back(wr_addr);
        obs_data.push_back(wr_data);
      end
      tk    = enable && (mcnt == SI - 1);
      mcnt  = (!enable || mcnt == SI - 1) ? 0 : mcnt + 1;
      drop  = tk && m_busy;
      nwrap = 0;
      if (m_req && wr_ack && mq.size() > 0) begin
        e = mq.pop_front();
        if (mptr[e.ch] == 2'd3) begin
          mptr[e.ch]  = 0;
          nwrap[e.ch] = 1'b1;
        end else begin
          mptr[e.ch] = mptr[e.ch] + 2'd1;
        end
        m_req = 0;
        if (mq.size() > 0) req_rise = cyc + 2; else idle_at = cyc + 2;
      end
      if (tk && !m_busy) begin
        for (int ch = 0; ch < 2; ch++) begin
          if (ch_mask[ch]) begin
            e.addr = tb_base[ch] + 12'(mptr[ch]);
            e.data = adc_data[ch*32 +: 32];
            e.ch   = ch;
            mq.push_back(e);
          end
        end
        m_busy = 1;
        if (mq.size() > 0) req_rise = cyc + 2; else idle_at = cyc + 2;
      end
      m_wrap = nwrap;
      if (overrun_clr) begin
        m_ovr = 0; m_ocnt = 0;
      end else if (drop) begin
        m_ovr = 1;
        if (m_ocnt < 255) m_ocnt++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycle=%0d limit reached", cyc);
    $fatal(1);
  end

  initial begin
    logic [31:0] d0;
    int          n;
    reset = 1'b1; enable = 1'b0; ch_mask = 2'b00; adc_data = '0; wr_ack = 1'b0; overrun_clr = 1'b0;
    step(3);
    chk("reset_busy", busy, 0);
    chk("reset_req", wr_req, 0);
    reset = 1'b0;

    // 1) both channels, ack tied high
    ch_mask = 2'b11; wr_ack = 1'b1; adc_data = {32'hB, 32'hA}; enable = 1'b1;
    obs_addr.delete(); obs_data.delete();
    step(8);
    chk("t1_req_before", wr_req, 0);
    step(1);
    chk("t1_req_latency", wr_req, 1);
    enable = 1'b0;
    step(8);
    chk("t1_nwrites", obs_addr.size(), 2);
    if (obs_addr.size() == 2) begin
      chk("t1_addr0", obs_addr[0], 12'h400);
      chk("t1_data0", obs_data[0], 32'hA);
      chk("t1_addr1", obs_addr[1], 12'h800);
      chk("t1_data1", obs_data[1], 32'hB);
    end
    chk("t1_ptr", wr_ptr, 4'b0101);

    // 2) four ticks on channel 0 only
    do_reset();
    ch_mask = 2'b01; wr_ack = 1'b1; adc_data = {$urandom, $urandom}; enable = 1'b1;
    obs_addr.delete(); obs_data.delete(); wrap_seen = 0;
    step(32);
    enable = 1'b0;
    step(8);
    chk("t2_nwrites", obs_addr.size(), 4);
    for (int i = 0; i < 4 && i < obs_addr.size(); i++) chk("t2_addr", obs_addr[i], 12'h400 + 12'(i));
    chk("t2_wrap_seen", wrap_seen, 1);
    chk("t2_ptr", wr_ptr, 4'b0000);

    // 3) ack withheld: stable request, one dropped tick, then clear
    do_reset();
    d0 = $urandom;
    ch_mask = 2'b01; wr_ack = 1'b0; adc_data = {32'h0, d0}; enable = 1'b1;
    obs_addr.delete(); obs_data.delete();
    step(17);
    enable = 1'b0;
    adc_data = {$urandom, $urandom};
    step(12);
    chk("t3_req_held", wr_req, 1);
    chk("t3_addr_held", wr_addr, 12'h400);
    chk("t3_data_held", wr_data, d0);
    chk("t3_overrun", overrun, 1);
    chk("t3_overrun_cnt", overrun_cnt, 1);
    wr_ack = 1'b1;
    step(1);
    wr_ack = 1'b0;
    step(5);
    chk("t3_one_write", obs_addr.size(), 1);
    overrun_clr = 1'b1;
    step(1);
    overrun_clr = 1'b0;
    chk("t3_clr_overrun", overrun, 0);
    chk("t3_clr_cnt", overrun_cnt, 0);

    // clear and drop in the same cycle: clear wins
    ch_mask = 2'b11; enable = 1'b1;
    n = 0;
    while (!(m_busy && m_req && mcnt == SI - 1) && n < 60) begin
      step(1);
      n++;
    end
    chk("t3_wait_tick", n < 60, 1);
    overrun_clr = 1'b1;
    step(1);
    overrun_clr = 1'b0;
    chk("t3_clr_wins_cnt", overrun_cnt, 0);
    chk("t3_clr_wins_flag", overrun, 0);

    // saturation of the drop counter
    step(SI * 260);
    chk("t3_saturate", overrun_cnt, 8'hFF);
    wr_ack = 1'b1; overrun_clr = 1'b1;
    step(1);
    overrun_clr = 1'b0; enable = 1'b0;
    step(10);

    // 4) data changes every cycle during sequences with random ack
    do_reset();
    ch_mask = 2'b11; enable = 1'b1;
    for (int i = 0; i < 80; i++) begin
      adc_data = {$urandom, $urandom};
      wr_ack   = 1'($urandom_range(0, 1));
      step(1);
    end

    // randomized operation
    for (int i = 0; i < 500; i++) begin
      adc_data    = {$urandom, $urandom};
      wr_ack      = ($urandom_range(0, 3) != 0);
      overrun_clr = ($urandom_range(0, 30) == 0);
      if ($urandom_range(0, 15) == 0) ch_mask = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 40) == 0) enable = ~enable;
      step(1);
    end
    overrun_clr = 1'b0;

    // 5) reset in the middle of a write, then an empty-mask sequence
    do_reset();
    ch_mask = 2'b11; wr_ack = 1'b0; enable = 1'b1;
    n = 0;
    while (wr_req !== 1'b1 && n < 40) begin
      step(1);
      n++;
    end
    chk("t5_reached_write", wr_req, 1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("t5_req_abandoned", wr_req, 0);
    chk("t5_busy_cleared", busy, 0);
    chk("t5_ptr_cleared", wr_ptr, 4'b0000);
    ch_mask = 2'b00; wr_ack = 1'b1; enable = 1'b1;
    obs_addr.delete(); obs_data.delete();
    step(20);
    enable = 1'b0;
    step(4);
    chk("t5_no_writes", obs_addr.size(), 0);
    chk("t5_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
